gesture_cmd_sched: RTL and testbench

Sits between the gesture sensor top and the vending/beep consumers. Turns raw gesture data into one-hot commands:
- detects rising edges on the gesture bits,
- suppresses repeats of the same gesture within a lockout window,
- buffers accepted commands in a small FIFO,
- hands commands one at a time to the vending FSM over a valid/ready handshake,
- schedules a fixed-length beep acknowledgement for each delivered command.

---
 rtl/gesture_cmd_sched_if.sv | 22 ++
 rtl/gesture_cmd_sched.sv | 151 +++++++++++++++
 tb/tb_gesture_cmd_sched.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gesture_cmd_sched_if.sv
// rtl/gesture_cmd_sched_if.sv - gesture command scheduler sensor/consumer bus
interface gesture_cmd_sched_if #(
   parameter int DEPTH_LOG2 = 2
);
   logic [7:0]            gest_data;
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [3:0]            cmd_code;
   logic                  beep_req;
   logic [DEPTH_LOG2:0]   fifo_level;
   logic [7:0]            drop_cnt;

   modport master (
      output gest_data, cmd_ready,
      input  cmd_valid, cmd_code, beep_req, fifo_level, drop_cnt
   );

   modport slave (
      input  gest_data, cmd_ready,
      output cmd_valid, cmd_code, beep_req, fifo_level, drop_cnt
   );
endinterface

// File: rtl/gesture_cmd_sched.sv
// rtl/gesture_cmd_sched.sv - gesture edge detect, repeat lockout, command FIFO and beep ack
module gesture_cmd_sched #(
   parameter int LOCKOUT_CYC = 25_000_000,
   parameter int BEEP_CYC    = 5_000_000,
   parameter int DEPTH_LOG2  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   gesture_cmd_sched_if.slave bus
);
   localparam int DEPTH   = 1 << DEPTH_LOG2;
   localparam int LVL_W   = DEPTH_LOG2 + 1;
   localparam int LOCK_W  = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
   localparam int BEEP_W  = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;
   localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYC - 1);
   localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEP_CYC - 1);

   typedef enum logic {L_IDLE, L_LOCK} lock_state_t;
   typedef enum logic {B_IDLE, B_ON}   beep_state_t;

   logic [3:0] g_r, g_d, pedge;
   logic       pedge_multi, pedge_single;
   logic       unused_gest_hi;

   logic [3:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [LVL_W-1:0]      level;
   logic                  full, pop, accept, push, drop;
   logic [7:0]            drop_cnt;

   lock_state_t       lock_state, lock_next;
   logic [LOCK_W-1:0] lock_cnt, lock_cnt_next;
   logic [3:0]        last_code, last_code_next;

   beep_state_t       beep_state, beep_next;
   logic [BEEP_W-1:0] beep_cnt, beep_cnt_next;

   assign unused_gest_hi = ^bus.gest_data[7:4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_r <= 4'd0;
         g_d <= 4'd0;
      end else begin
         g_r <= bus.gest_data[3:0];
         g_d <= g_r;
      end
   end

   // x & (x-1) clears the lowest set bit; anything left means two or more edges
   assign pedge        = g_r & ~g_d;
   assign pedge_multi  = |(pedge & (pedge - 4'd1));
   assign pedge_single = (pedge != 4'd0) && !pedge_multi;

   assign full   = (level == LVL_W'(DEPTH));
   assign pop    = (level != '0) && bus.cmd_ready;
   assign accept = pedge_single && ((lock_state == L_IDLE) || (pedge != last_code));
   assign push   = accept && (!full || pop);
   assign drop   = pedge_multi || (accept && full && !pop);

   // Storage is not reset: the head is masked by cmd_valid, so stale entries never leak
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= pedge;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         drop_cnt <= 8'd0;
      else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_state <= L_IDLE;
         lock_cnt   <= '0;
         last_code  <= 4'd0;
      end else begin
         lock_state <= lock_next;
         lock_cnt   <= lock_cnt_next;
         last_code  <= last_code_next;
      end
   end

   always_comb begin
      lock_next      = lock_state;
      lock_cnt_next  = lock_cnt;
      last_code_next = last_code;
      case (lock_state)
         L_IDLE: ;
         L_LOCK: begin
            if (lock_cnt == '0) lock_next     = L_IDLE;
            else                lock_cnt_next = lock_cnt - LOCK_W'(1);
         end
         default: lock_next = L_IDLE;
      endcase
      // Only a command that actually reached the FIFO arms the lockout
      if (push) begin
         lock_next      = L_LOCK;
         lock_cnt_next  = LOCK_LOAD;
         last_code_next = pedge;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beep_state <= B_IDLE;
         beep_cnt   <= '0;
      end else begin
         beep_state <= beep_next;
         beep_cnt   <= beep_cnt_next;
      end
   end

   always_comb begin
      beep_next     = beep_state;
      beep_cnt_next = beep_cnt;
      case (beep_state)
         B_IDLE: ;
         B_ON: begin
            if (beep_cnt == '0) beep_next     = B_IDLE;
            else                beep_cnt_next = beep_cnt - BEEP_W'(1);
         end
         default: beep_next = B_IDLE;
      endcase
      if (pop) begin
         beep_next     = B_ON;
         beep_cnt_next = BEEP_LOAD;
      end
   end

   assign bus.cmd_valid  = (level != '0);
   assign bus.cmd_code   = bus.cmd_valid ? mem[rd_ptr] : 4'd0;
   assign bus.beep_req   = (beep_state == B_ON);
   assign bus.fifo_level = level;
   assign bus.drop_cnt   = drop_cnt;
endmodule

// File: tb/tb_gesture_cmd_sched.sv
// tb/tb_gesture_cmd_sched.sv - self-checking bench for gesture_cmd_sched
module tb_gesture_cmd_sched;
   localparam int LOCK  = 20;
   localparam int BEEP  = 5;
   localparam int DL    = 2;
   localparam int DEPTH = 1 << DL;

   logic clk;
   logic rst_n;

   gesture_cmd_sched_if #(.DEPTH_LOG2(DL)) bus ();

   gesture_cmd_sched #(
      .LOCKOUT_CYC (LOCK),
      .BEEP_CYC    (BEEP),
      .DEPTH_LOG2  (DL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour: command queue, time-of-last-acceptance lockout, remaining beep time
   int         cyc        = 0;
   logic [3:0] m_prev     = 4'd0;
   logic [3:0] m_pend     = 4'd0;
   int         m_q[$];
   int         m_drop     = 0;
   int         m_beep     = 0;
   int         m_last     = 0;
   int         m_last_cyc = 0;
   bit         m_has_last = 1'b0;

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         m_q.delete();
         m_prev     = 4'd0;
         m_pend     = 4'd0;
         m_drop     = 0;
         m_beep     = 0;
         m_has_last = 1'b0;
      end else begin
         if (m_q.size() > 0 && bus.cmd_ready) begin
            void'(m_q.pop_front());
            m_beep = BEEP;
         end else if (m_beep > 0) begin
            m_beep--;
         end
         if ($countones(m_pend) > 1) begin
            if (m_drop < 255) m_drop++;
         end else if ($countones(m_pend) == 1) begin
            if (m_has_last && int'(m_pend) == m_last && (cyc - m_last_cyc) <= LOCK) begin
            end else if (m_q.size() == DEPTH) begin
               if (m_drop < 255) m_drop++;
            end else begin
               m_q.push_back(int'(m_pend));
               m_last     = int'(m_pend);
               m_last_cyc = cyc;
               m_has_last = 1'b1;
            end
         end
         m_pend = bus.gest_data[3:0] & ~m_prev;
         m_prev = bus.gest_data[3:0];
      end
      #1;
      chk("cmp_valid", int'(bus.cmd_valid),  (m_q.size() > 0) ? 1 : 0);
      chk("cmp_code",  int'(bus.cmd_code),   (m_q.size() > 0) ? m_q[0] : 0);
      chk("cmp_level", int'(bus.fifo_level), m_q.size());
      chk("cmp_drop",  int'(bus.drop_cnt),   m_drop);
      chk("cmp_beep",  int'(bus.beep_req),   (m_beep > 0) ? 1 : 0);
   end

   int pop_log[$];
   always @(posedge clk) begin
      if (rst_n && bus.cmd_valid && bus.cmd_ready) pop_log.push_back(int'(bus.cmd_code));
   end

   task automatic chk_log(input string name, input int n,
                          input int e0, input int e1, input int e2, input int e3, input int e4);
      int e[5];
      e = '{e0, e1, e2, e3, e4};
      chk({name, "_count"}, pop_log.size(), n);
      for (int i = 0; i < n && i < pop_log.size(); i++) chk(name, pop_log[i], e[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic [7:0] v);
      bus.gest_data = v;
      @(negedge clk);
      bus.gest_data = 8'h00;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.gest_data = 8'h00;
      bus.cmd_ready = 1'b0;
      pop_log.delete();
      idle(2);
      rst_n = 1'b1;
   endtask

   int beeps;

   initial begin
      rst_n = 1'b0;
      bus.gest_data = 8'h00;
      bus.cmd_ready = 1'b0;
      idle(3);
      chk("rst_valid", int'(bus.cmd_valid),  0);
      chk("rst_code",  int'(bus.cmd_code),   0);
      chk("rst_level", int'(bus.fifo_level), 0);
      chk("rst_drop",  int'(bus.drop_cnt),   0);
      chk("rst_beep",  int'(bus.beep_req),   0);
      rst_n = 1'b1;
      idle(2);

      // single held event, ready high
      bus.cmd_ready = 1'b1;
      bus.gest_data = 8'h01;
      @(negedge clk);
      chk("t1_valid_early", int'(bus.cmd_valid), 0);
      @(negedge clk);
      chk("t1_valid", int'(bus.cmd_valid),  1);
      chk("t1_code",  int'(bus.cmd_code),   1);
      chk("t1_level", int'(bus.fifo_level), 1);
      @(negedge clk);
      bus.gest_data = 8'h00;
      chk("t1_valid_after", int'(bus.cmd_valid), 0);
      beeps = int'(bus.beep_req);
      repeat (10) begin
         @(negedge clk);
         beeps += int'(bus.beep_req);
      end
      chk("t1_beep_len", beeps, 5);
      chk("t1_level_end", int'(bus.fifo_level), 0);
      chk_log("t1_log", 1, 1, 0, 0, 0, 0);

      // lockout of repeats, different code accepted while locked
      do_reset();
      bus.cmd_ready = 1'b1;
      pulse(8'h02); idle(9);
      pulse(8'h02); idle(14);
      pulse(8'h02); idle(30);
      pulse(8'h02); idle(2);
      pulse(8'h04); idle(10);
      chk("t2_drop", int'(bus.drop_cnt), 0);
      chk_log("t2_log", 4, 2, 2, 2, 4, 0);

      // back-pressure until full, fifth event dropped
      do_reset();
      pulse(8'h01); idle(2);
      pulse(8'h02); idle(2);
      pulse(8'h04); idle(2);
      pulse(8'h08); idle(2);
      pulse(8'h01); idle(4);
      chk("t3_level", int'(bus.fifo_level), 4);
      chk("t3_drop",  int'(bus.drop_cnt),   1);
      chk("t3_head",  int'(bus.cmd_code),   1);
      bus.cmd_ready = 1'b1;
      idle(8);
      chk("t3_level_end", int'(bus.fifo_level), 0);
      chk_log("t3_log", 4, 1, 2, 4, 8, 0);

      // full FIFO with pop on the push edge
      do_reset();
      pulse(8'h01); idle(2);
      pulse(8'h02); idle(2);
      pulse(8'h04); idle(2);
      pulse(8'h08); idle(4);
      chk("t4_level_full", int'(bus.fifo_level), 4);
      bus.gest_data = 8'h02;
      @(negedge clk);
      bus.gest_data = 8'h00;
      bus.cmd_ready = 1'b1;
      @(negedge clk);
      bus.cmd_ready = 1'b0;
      chk("t4_level", int'(bus.fifo_level), 4);
      chk("t4_drop",  int'(bus.drop_cnt),   0);
      chk("t4_head",  int'(bus.cmd_code),   2);
      bus.cmd_ready = 1'b1;
      idle(8);
      chk_log("t4_log", 5, 1, 2, 4, 8, 2);

      // multi-bit edges are dropped, counter saturates
      do_reset();
      pulse(8'h03); idle(3);
      chk("t5_drop_one", int'(bus.drop_cnt),  1);
      chk("t5_valid",    int'(bus.cmd_valid), 0);
      repeat (300) begin
         pulse(8'h03);
         idle(1);
      end
      idle(3);
      chk("t5_drop_sat", int'(bus.drop_cnt), 255);

      // reset during beep with two commands queued
      do_reset();
      pulse(8'h0C); idle(1);
      bus.cmd_ready = 1'b1;
      bus.gest_data = 8'h01;
      @(negedge clk);
      bus.gest_data = 8'h03;
      @(negedge clk);
      bus.gest_data = 8'h07;
      @(negedge clk);
      bus.cmd_ready = 1'b0;
      idle(2);
      chk("t6_level_pre", int'(bus.fifo_level), 2);
      chk("t6_beep_pre",  int'(bus.beep_req),   1);
      chk("t6_head_pre",  int'(bus.cmd_code),   2);
      chk("t6_drop_pre",  int'(bus.drop_cnt),   1);
      rst_n = 1'b0;
      bus.gest_data = 8'h00;
      #1;
      chk("t6_rst_valid", int'(bus.cmd_valid),  0);
      chk("t6_rst_beep",  int'(bus.beep_req),   0);
      chk("t6_rst_level", int'(bus.fifo_level), 0);
      chk("t6_rst_drop",  int'(bus.drop_cnt),   0);
      pop_log.delete();
      idle(2);
      rst_n = 1'b1;
      bus.cmd_ready = 1'b1;
      idle(10);
      chk("t6_no_stale", pop_log.size(), 0);
      chk("t6_valid_end", int'(bus.cmd_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
